// File: rtl/fft512_peak_sink_if.sv
// AXI4-Stream style link carrying FFT output bins into the peak sink.
//   s_axis_tdata  : [15:0] real, [31:16] imaginary, signed two's complement
//   s_axis_tvalid : beat valid from the FFT master
//   s_axis_tlast  : marks bin 511 of a frame
//   s_axis_tready : sink ready; a beat transfers when tvalid and tready are both 1
interface fft512_peak_sink_if;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;

    modport master (
        output s_axis_tdata,
        output s_axis_tvalid,
        output s_axis_tlast,
        input  s_axis_tready
    );

    modport slave (
        input  s_axis_tdata,
        input  s_axis_tvalid,
        input  s_axis_tlast,
        output s_axis_tready
    );
endinterface

// File: rtl/fft512_peak_sink.sv
// Consumes 512-bin FFT frames and reports the strongest bin in [BIN_LO, BIN_HI].
// Ports:
//   clk        : single clock, rising edge
//   reset      : asynchronous active-low reset
//   s_axis     : stream slave (tdata/tvalid/tlast in, tready out)
//   peak_bin   : bin index of the largest in-band magnitude of the last good frame
//   peak_mag   : re^2+im^2 of that bin, unsigned
//   peak_valid : one-cycle pulse when peak_bin/peak_mag update
//   frame_err  : sticky tlast/bin-count mismatch flag, cleared only by reset
//   frame_cnt  : count of good frames reported, wraps
module fft512_peak_sink #(
    parameter int unsigned BIN_LO = 1,
    parameter int unsigned BIN_HI = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    fft512_peak_sink_if.slave         s_axis,
    output logic [8:0]                peak_bin,
    output logic [31:0]               peak_mag,
    output logic                      peak_valid,
    output logic                      frame_err,
    output logic [15:0]               frame_cnt
);

    localparam int unsigned BIN_W = 9;
    localparam int unsigned SQ_W  = 31;
    localparam int unsigned MAG_W = 32;
    localparam int unsigned CNT_W = 16;
    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(511);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_REPORT,
        ST_DRAIN
    } state_e;

    state_e             state_q;
    logic [BIN_W-1:0]   bin_q;
    logic               flush_q;
    logic               tready_q;

    logic               s1_v_q;
    logic [SQ_W-1:0]    s1_re2_q;
    logic [SQ_W-1:0]    s1_im2_q;
    logic [BIN_W-1:0]   s1_bin_q;

    logic [MAG_W-1:0]   max_mag_q;
    logic [BIN_W-1:0]   max_bin_q;

    logic [BIN_W-1:0]   peak_bin_q;
    logic [MAG_W-1:0]   peak_mag_q;
    logic               peak_valid_q;
    logic               frame_err_q;
    logic [CNT_W-1:0]   frame_cnt_q;

    // Squares of the incoming beat; (-32768)^2 = 2^30 still fits in 31 bits.
    logic signed [15:0] re_c;
    logic signed [15:0] im_c;
    logic signed [31:0] re_sq_c;
    logic signed [31:0] im_sq_c;
    logic               accept_c;
    logic [MAG_W-1:0]   mag_c;
    logic               in_band_c;
    logic               upd_c;

    assign re_c     = $signed(s_axis.s_axis_tdata[15:0]);
    assign im_c     = $signed(s_axis.s_axis_tdata[31:16]);
    assign re_sq_c  = 32'(re_c) * 32'(re_c);
    assign im_sq_c  = 32'(im_c) * 32'(im_c);
    assign accept_c = s_axis.s_axis_tvalid & tready_q;

    // Stage 2 compare: strictly greater keeps the lower bin on ties.
    assign mag_c     = MAG_W'(s1_re2_q) + MAG_W'(s1_im2_q);
    assign in_band_c = (32'(s1_bin_q) >= BIN_LO) && (32'(s1_bin_q) <= BIN_HI);
    assign upd_c     = s1_v_q && in_band_c && (mag_c > max_mag_q);

    assign s_axis.s_axis_tready = tready_q;
    assign peak_bin   = peak_bin_q;
    assign peak_mag   = peak_mag_q;
    assign peak_valid = peak_valid_q;
    assign frame_err  = frame_err_q;
    assign frame_cnt  = frame_cnt_q;

    // Frame sequencing, two-stage magnitude pipeline and report registers.
    // Later assignments in the case override the stage-2 update when a frame is discarded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_RUN;
            bin_q        <= '0;
            flush_q      <= 1'b0;
            tready_q     <= 1'b0;
            s1_v_q       <= 1'b0;
            s1_re2_q     <= '0;
            s1_im2_q     <= '0;
            s1_bin_q     <= '0;
            max_mag_q    <= '0;
            max_bin_q    <= '0;
            peak_bin_q   <= '0;
            peak_mag_q   <= '0;
            peak_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            peak_valid_q <= 1'b0;
            s1_v_q       <= 1'b0;

            if (upd_c) begin
                max_mag_q <= mag_c;
                max_bin_q <= s1_bin_q;
            end

            case (state_q)
                ST_RUN: begin
                    tready_q <= 1'b1;
                    if (accept_c) begin
                        if (s_axis.s_axis_tlast && (bin_q != LAST_BIN)) begin
                            // Early tlast: drop the frame, including any beat still in stage 1.
                            frame_err_q <= 1'b1;
                            bin_q       <= '0;
                            max_mag_q   <= '0;
                            max_bin_q   <= '0;
                        end else if (!s_axis.s_axis_tlast && (bin_q == LAST_BIN)) begin
                            // Missing tlast: throw beats away until the master sends one.
                            frame_err_q <= 1'b1;
                            bin_q       <= '0;
                            state_q     <= ST_DRAIN;
                        end else begin
                            s1_v_q   <= 1'b1;
                            s1_re2_q <= SQ_W'(re_sq_c);
                            s1_im2_q <= SQ_W'(im_sq_c);
                            s1_bin_q <= bin_q;
                            bin_q    <= bin_q + BIN_W'(1);
                            if (bin_q == LAST_BIN) begin
                                state_q  <= ST_FLUSH;
                                flush_q  <= 1'b0;
                                tready_q <= 1'b0;
                            end
                        end
                    end
                end

                ST_FLUSH: begin
                    // Two stalled cycles let bin 511 pass stage 1 and stage 2.
                    tready_q <= 1'b0;
                    flush_q  <= 1'b1;
                    if (flush_q) begin
                        state_q <= ST_REPORT;
                    end
                end

                ST_REPORT: begin
                    peak_bin_q   <= max_bin_q;
                    peak_mag_q   <= max_mag_q;
                    peak_valid_q <= 1'b1;
                    frame_cnt_q  <= frame_cnt_q + CNT_W'(1);
                    bin_q        <= '0;
                    max_mag_q    <= '0;
                    max_bin_q    <= '0;
                    tready_q     <= 1'b1;
                    state_q      <= ST_RUN;
                end

                ST_DRAIN: begin
                    tready_q <= 1'b1;
                    if (accept_c && s_axis.s_axis_tlast) begin
                        bin_q     <= '0;
                        max_mag_q <= '0;
                        max_bin_q <= '0;
                        state_q   <= ST_RUN;
                    end
                end

                default: begin
                    state_q  <= ST_RUN;
                    tready_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft512_peak_sink.sv
// Self-checking bench for fft512_peak_sink: frame-level stimulus against a
// plain-arithmetic peak search over the frame array.
module tb_fft512_peak_sink;

    localparam int unsigned BIN_LO  = 1;
    localparam int unsigned BIN_HI  = 255;
    localparam int          TIMEOUT = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  peak_bin;
    logic [31:0] peak_mag;
    logic        peak_valid;
    logic        frame_err;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    fft512_peak_sink_if bus ();

    fft512_peak_sink #(
        .BIN_LO (BIN_LO),
        .BIN_HI (BIN_HI)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .s_axis     (bus.slave),
        .peak_bin   (peak_bin),
        .peak_mag   (peak_mag),
        .peak_valid (peak_valid),
        .frame_err  (frame_err),
        .frame_cnt  (frame_cnt)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          acc_cyc  = 0;
    int          exp_cnt  = 0;
    logic [31:0] frame_data [512];

    int     pv_cyc [$];
    int     pv_bin [$];
    longint pv_mag [$];
    int     pv_cnt [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Record every report pulse with the cycle it appeared in.
    always @(negedge clk) begin
        if (peak_valid === 1'b1) begin
            pv_cyc.push_back(cyc);
            pv_bin.push_back(int'(peak_bin));
            pv_mag.push_back(longint'(peak_mag));
            pv_cnt.push_back(int'(frame_cnt));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1);
    end

    function automatic logic [31:0] mk_sample(input int re, input int im);
        return {16'(im), 16'(re)};
    endfunction

    // Reference: largest re^2+im^2 over the band, first occurrence wins.
    function automatic void model_peak(output int bin, output longint mag);
        bin = 0;
        mag = 0;
        for (int b = int'(BIN_LO); b <= int'(BIN_HI) && b < 512; b++) begin
            longint re;
            longint im;
            longint m;
            re = $signed(frame_data[b][15:0]);
            im = $signed(frame_data[b][31:16]);
            m  = re * re + im * im;
            if (m > mag) begin
                mag = m;
                bin = b;
            end
        end
    endfunction

    task automatic clear_frame();
        for (int i = 0; i < 512; i++) frame_data[i] = 32'h0;
    endtask

    task automatic rand_frame();
        for (int i = 0; i < 512; i++) frame_data[i] = $urandom;
    endtask

    task automatic clear_reports();
        pv_cyc.delete();
        pv_bin.delete();
        pv_mag.delete();
        pv_cnt.delete();
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata  = $urandom;
        bus.s_axis_tlast  = 1'($urandom);
    endtask

    task automatic send_beat(input logic [31:0] d, input logic last);
        int n;
        n = 0;
        @(negedge clk);
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tdata  = d;
        bus.s_axis_tlast  = last;
        while (bus.s_axis_tready !== 1'b1 && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        if (n >= TIMEOUT) begin
            n_checks++;
            n_fail++;
            $display("FAIL beat_timeout: tready=%b stayed low for %0d cycles, required 1", bus.s_axis_tready, n);
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
    endtask

    task automatic send_stream(input int n_beats, input int tlast_idx, input int gap_pct);
        for (int i = 0; i < n_beats; i++) begin
            if (int'($urandom_range(99)) < gap_pct) idle_cycle();
            send_beat(frame_data[i % 512], i == tlast_idx);
        end
        idle_cycle();
    endtask

    task automatic wait_report(input string name, input int exp_bin, input longint exp_mag);
        int n;
        n = 0;
        while (pv_cyc.size() == 0 && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (pv_cyc.size() == 0) begin
            n_fail++;
            $display("FAIL %s_report: no peak_valid within %0d cycles, required one", name, TIMEOUT);
            return;
        end
        n_checks++;
        if (pv_cyc[0] - acc_cyc !== 3) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d cycles, required 3", name, pv_cyc[0] - acc_cyc);
        end
        n_checks++;
        if (pv_bin[0] !== exp_bin) begin
            n_fail++;
            $display("FAIL %s_bin: got %0d, required %0d", name, pv_bin[0], exp_bin);
        end
        n_checks++;
        if (pv_mag[0] !== exp_mag) begin
            n_fail++;
            $display("FAIL %s_mag: got 0x%0h, required 0x%0h", name, pv_mag[0], exp_mag);
        end
        n_checks++;
        if (pv_cnt[0] !== exp_cnt) begin
            n_fail++;
            $display("FAIL %s_frame_cnt: got %0d, required %0d", name, pv_cnt[0], exp_cnt);
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (pv_cyc.size() !== 1) begin
            n_fail++;
            $display("FAIL %s_pulse_count: got %0d pulses, required 1", name, pv_cyc.size());
        end
        n_checks++;
        if (int'(peak_bin) !== exp_bin || longint'(peak_mag) !== exp_mag) begin
            n_fail++;
            $display("FAIL %s_hold: got bin %0d mag 0x%0h, required bin %0d mag 0x%0h",
                     name, peak_bin, peak_mag, exp_bin, exp_mag);
        end
    endtask

    task automatic check_no_report(input string name);
        repeat (8) @(negedge clk);
        n_checks++;
        if (pv_cyc.size() !== 0) begin
            n_fail++;
            $display("FAIL %s_no_pulse: got %0d pulses, required 0", name, pv_cyc.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata  = 32'h0;
        bus.s_axis_tlast  = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (peak_bin !== 9'd0 || peak_mag !== 32'd0 || peak_valid !== 1'b0 ||
            frame_err !== 1'b0 || frame_cnt !== 16'd0 || bus.s_axis_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got bin %0d mag %0d pv %b err %b cnt %0d rdy %b, required all 0",
                     peak_bin, peak_mag, peak_valid, frame_err, frame_cnt, bus.s_axis_tready);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.s_axis_tready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_tready_rise: got %b, required 1", bus.s_axis_tready);
        end
    endtask

    task automatic test_single_bin();
        clear_reports();
        clear_frame();
        frame_data[40] = mk_sample(100, -200);
        for (int i = 0; i < 511; i++) send_beat(frame_data[i], 1'b0);
        send_beat(frame_data[511], 1'b1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) bus.s_axis_tvalid = 1'b0;
            n_checks++;
            if (bus.s_axis_tready !== (k == 4)) begin
                n_fail++;
                $display("FAIL single_tready_window: cycle %0d got %b, required %b", k, bus.s_axis_tready, k == 4);
            end
        end
        exp_cnt = 1;
        wait_report("single", 40, 50000);
    endtask

    task automatic test_tie();
        clear_reports();
        clear_frame();
        frame_data[0]  = mk_sample(32767, 0);
        frame_data[10] = mk_sample(300, 400);
        frame_data[20] = mk_sample(300, 400);
        send_stream(512, 511, 0);
        exp_cnt++;
        wait_report("tie", 10, 250000);
    endtask

    task automatic test_band_edges();
        clear_reports();
        clear_frame();
        frame_data[0]   = mk_sample(-32768, -32768);
        frame_data[1]   = mk_sample(5, 0);
        frame_data[255] = mk_sample(0, -5);
        frame_data[256] = mk_sample(20000, 20000);
        frame_data[511] = mk_sample(30000, 1);
        send_stream(512, 511, 10);
        exp_cnt++;
        wait_report("band_edges", 1, 25);
    endtask

    task automatic test_all_zero();
        clear_reports();
        clear_frame();
        frame_data[0]   = mk_sample(1234, 99);
        frame_data[300] = mk_sample(-500, 7);
        send_stream(512, 511, 0);
        exp_cnt++;
        wait_report("all_zero", 0, 0);
    endtask

    task automatic test_early_tlast();
        int     eb;
        longint em;
        clear_reports();
        rand_frame();
        send_stream(101, 100, 0);
        n_checks++;
        if (frame_err !== 1'b1) begin
            n_fail++;
            $display("FAIL early_tlast_err: got %b, required 1", frame_err);
        end
        check_no_report("early_tlast");
        rand_frame();
        model_peak(eb, em);
        send_stream(512, 511, 0);
        exp_cnt++;
        wait_report("after_early", eb, em);
    endtask

    task automatic test_missing_tlast();
        int     eb;
        longint em;
        clear_reports();
        rand_frame();
        send_stream(517, 516, 0);
        n_checks++;
        if (frame_err !== 1'b1) begin
            n_fail++;
            $display("FAIL missing_tlast_err: got %b, required 1", frame_err);
        end
        check_no_report("missing_tlast");
        rand_frame();
        model_peak(eb, em);
        send_stream(512, 511, 15);
        exp_cnt++;
        wait_report("after_drain", eb, em);
    endtask

    task automatic test_gaps_max();
        int     eb;
        longint em;
        clear_reports();
        rand_frame();
        for (int i = 0; i < 512; i++) begin
            if (frame_data[i] == 32'h8000_8000) frame_data[i] = 32'h1;
        end
        frame_data[255] = mk_sample(-32768, -32768);
        model_peak(eb, em);
        n_checks++;
        if (eb !== 255 || em !== 64'h8000_0000) begin
            n_fail++;
            $display("FAIL gaps_model_setup: got bin %0d mag 0x%0h, required 255 0x80000000", eb, em);
        end
        send_stream(512, 511, 30);
        exp_cnt++;
        wait_report("gaps_max", 255, 64'h8000_0000);
    endtask

    task automatic test_random_frames();
        int     eb;
        longint em;
        for (int f = 0; f < 3; f++) begin
            clear_reports();
            rand_frame();
            frame_data[0]   = mk_sample(32767, 32767);
            frame_data[256] = mk_sample(-32768, -32768);
            model_peak(eb, em);
            send_stream(512, 511, 20);
            exp_cnt++;
            wait_report("random", eb, em);
        end
    endtask

    task automatic test_reset_midframe();
        int     eb;
        longint em;
        clear_reports();
        rand_frame();
        for (int i = 0; i < 300; i++) send_beat(frame_data[i], 1'b0);
        #2;
        reset = 1'b0;
        bus.s_axis_tvalid = 1'b0;
        #1;
        n_checks++;
        if (peak_bin !== 9'd0 || peak_mag !== 32'd0 || peak_valid !== 1'b0 ||
            frame_err !== 1'b0 || frame_cnt !== 16'd0 || bus.s_axis_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_async: got bin %0d mag %0d pv %b err %b cnt %0d rdy %b, required all 0",
                     peak_bin, peak_mag, peak_valid, frame_err, frame_cnt, bus.s_axis_tready);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.s_axis_tready !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_tready_rise: got %b, required 1", bus.s_axis_tready);
        end
        check_no_report("midreset");
        exp_cnt = 0;
        rand_frame();
        model_peak(eb, em);
        send_stream(512, 511, 10);
        exp_cnt++;
        wait_report("after_reset", eb, em);
    endtask

    initial begin
        test_reset();
        test_single_bin();
        test_tie();
        test_band_edges();
        test_all_zero();
        test_early_tlast();
        test_missing_tlast();
        test_gaps_max();
        test_random_frames();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
